gmem_scheduler: RTL and testbench
=================================

GMEM_SCHEDULER -- requirements
Module: gmem_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 8, is the number of requesting cores; the legal range is 2..8.
REQ-002 Parameter MAX_LOCK, default 4, is the maximum number of consecutive cycles one requester may hold a locked grant.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset; asserted when 0 and sampled on rising clk.
REQ-005 Port request, input, NUM_REQ bits: bit i is core i's wren OR rden for the current cycle.
REQ-006 Port req_read, input, NUM_REQ bits: bit i is 1 when core i's request is a read; it is ignored when request[i]=0.
REQ-007 Port lock, input, NUM_REQ bits: bit i asks to keep the grant next cycle; it is functional only under GMEM_ARB_LOCK_EN.
REQ-008 Port grant_oh, output, NUM_REQ bits: one-hot grant, combinational, drives the cores' remote_ready; all zero when no request.
REQ-009 Port grant_id, output, 3 bits: binary index of the granted requester; 0 when no grant.
REQ-010 Port grant_valid, output, 1 bit: OR of grant_oh.
REQ-011 Port rdata_valid_oh, output, NUM_REQ bits: registered; one-hot marking the core whose read data appears on the shared read bus this cycle.
REQ-012 Port contention_count, output, 16 bits: registered saturating count of cycles in which two or more request bits were set.

Function
REQ-013 The block shall grant the lowest-index set request at or above priority pointer ptr, wrapping from NUM_REQ-1 to 0 (round robin).
REQ-014 On a cycle with grant_valid=1 and no lock hold, ptr shall become (granted index + 1) mod NUM_REQ at the next edge.
REQ-015 On a cycle with no request, ptr shall hold its value and grant_oh shall be 0.
REQ-016 Grant latency shall be zero cycles: request[i] high with i selected gives grant_oh[i]=1 in the same cycle.
REQ-017 rdata_valid_oh[i] shall be 1 exactly one cycle after a cycle with grant_oh[i]=1 and req_read[i]=1, matching the one-cycle global SRAM/device read latency; otherwise it shall be 0.
REQ-018 Back-to-back reads from different cores shall produce back-to-back single-bit rdata_valid_oh pulses in grant order.
REQ-019 contention_count shall increment by 1 on each cycle with popcount(request)>=2, and shall saturate at 16'hFFFF without wrapping.
REQ-020 A request that is dropped before it is granted shall not be granted and shall not move ptr.
REQ-021 grant_oh shall never have more than one bit set, and bit i shall only be set when request[i]=1 in the same cycle.

Reset
REQ-022 While reset=0 at a clock edge, the following shall be cleared: ptr=0, rdata_valid_oh=0, contention_count=0, lock owner cleared, lock counter=0.
REQ-023 During reset, grant_oh shall still follow REQ-013 with ptr=0 (purely combinational); the cores are themselves held in reset.
REQ-024 A reset asserted mid-lock or mid-read shall discard the lock and the pending rdata_valid pulse, with no pulse in the cycle after release.

Configuration
REQ-025 With macro GMEM_ARB_LOCK_EN defined, if the granted core i has lock[i]=1 and request[i]=1, core i shall be granted again next cycle regardless of ptr, and ptr shall not advance.
REQ-026 Under GMEM_ARB_LOCK_EN, the lock counter shall count consecutive held grants; after MAX_LOCK grants to the same owner the lock shall be ignored for one arbitration, and ptr shall advance past the owner.
REQ-027 Under GMEM_ARB_LOCK_EN, the lock shall release immediately when the owner drops request or lock.
REQ-028 Without GMEM_ARB_LOCK_EN, the lock port shall exist but be ignored, and no lock state shall be synthesized.

Verification
REQ-029 Reset, then request=8'hFF held for 8 cycles: grant_id shall be 0,1,...,7 in order, and contention_count shall be 8.
REQ-030 request=8'h81 with ptr=0, read on both: grants go to 0 then 7, and rdata_valid_oh is 8'h01 then 8'h80 on the following cycles.
REQ-031 Only core 5 requests, a write, for 3 cycles: grant_oh=8'h20 every cycle, rdata_valid_oh stays 0, and contention_count stays 0.
REQ-032 Force contention for 70000 cycles: contention_count shall stop at 16'hFFFF.
REQ-033 GMEM_ARB_LOCK_EN, core 2 holds lock with requests 8'h0C and MAX_LOCK=4: core 2 is granted 4 cycles, core 3 is granted on the 5th.
REQ-034 reset=0 asserted in the cycle after a granted read: rdata_valid_oh=0 and ptr=0 after release.

Source files
------------

// File: rtl/gmem_scheduler_if.sv
// Global memory scheduler bus: core-side request lines and scheduler-side
// grant / read-return / statistics outputs.
//
// Handshake: a core holds request[i] high for as long as it wants the bus;
// grant_oh[i] is its ready and the transfer happens in any cycle where both
// are high. Read data for that transfer is marked one cycle later by
// rdata_valid_oh[i].
interface gmem_scheduler_if #(
    parameter int NUM_REQ = 8
);
    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] req_read;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] grant_oh;
    logic [2:0]         grant_id;
    logic               grant_valid;
    logic [NUM_REQ-1:0] rdata_valid_oh;
    logic [15:0]        contention_count;

    // Core side: drives requests, observes grants.
    modport master (
        output request, req_read, lock,
        input  grant_oh, grant_id, grant_valid, rdata_valid_oh, contention_count
    );

    // Scheduler side: observes requests, drives grants.
    modport slave (
        input  request, req_read, lock,
        output grant_oh, grant_id, grant_valid, rdata_valid_oh, contention_count
    );
endinterface

// File: rtl/gmem_scheduler.sv
// Round-robin scheduler for the shared global SRAM/device port.
// Zero-latency combinational grant, one-cycle read-return marker and a
// saturating contention counter.
//
// Optional feature macro: GMEM_ARB_LOCK_EN. When defined, a granted core
// asserting lock keeps the bus for up to MAX_LOCK consecutive grants.
// When undefined, the lock lines are ignored and no lock state exists.
module gmem_scheduler #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic clk,
    input  logic reset,
    gmem_scheduler_if.slave bus
);

    logic [2:0]         ptr;
    logic [2:0]         ptr_next;
    logic [2:0]         rr_id;
    logic               rr_hit;
    logic [2:0]         sel_id;
    logic               sel_hit;
    logic               hold_next;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] rdata_valid_q;
    logic [15:0]        contention_q;
    logic               multi_req;

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        rr_hit = 1'b0;
        rr_id  = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!rr_hit && bus.request[idx]) begin
                rr_hit = 1'b1;
                rr_id  = 3'(idx);
            end
        end
    end

`ifdef GMEM_ARB_LOCK_EN
    logic        lock_active;
    logic [2:0]  lock_owner;
    logic [15:0] lock_cnt;
    logic        lock_held;
    logic [15:0] run_cnt;

    // Lock override: the owner keeps the bus while it still requests;
    // run_cnt is the number of consecutive grants including this one.
    always_comb begin
        lock_held = lock_active && bus.request[lock_owner];
        run_cnt   = lock_held ? lock_cnt + 16'd1 : 16'd1;
        sel_hit   = lock_held || rr_hit;
        sel_id    = lock_held ? lock_owner : rr_id;
        hold_next = sel_hit && bus.lock[sel_id] && (run_cnt < 16'(MAX_LOCK));
    end

    // Lock bookkeeping: arm on a locked grant, drop on release or limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_active <= 1'b0;
            lock_owner  <= 3'd0;
            lock_cnt    <= 16'd0;
        end else if (hold_next) begin
            lock_active <= 1'b1;
            lock_owner  <= sel_id;
            lock_cnt    <= run_cnt;
        end else begin
            lock_active <= 1'b0;
            lock_owner  <= 3'd0;
            lock_cnt    <= 16'd0;
        end
    end
`else
    logic unused_lock;

    // No lock support: the round-robin winner is the grant.
    always_comb begin
        sel_hit   = rr_hit;
        sel_id    = rr_id;
        hold_next = 1'b0;
    end

    assign unused_lock = (^bus.lock) ^ (MAX_LOCK > 0);
`endif

    // One-hot grant decode; all zero when nothing is requested.
    always_comb begin
        grant_oh = '0;
        if (sel_hit) grant_oh[sel_id] = 1'b1;
    end

    // Pointer moves past the winner unless the winner is keeping the bus.
    always_comb begin
        ptr_next = ptr;
        if (sel_hit && !hold_next) begin
            if (sel_id == 3'(NUM_REQ - 1)) ptr_next = 3'd0;
            else                           ptr_next = sel_id + 3'd1;
        end
    end

    // Two or more request bits set: clearing the lowest set bit leaves a bit.
    assign multi_req = |(bus.request & (bus.request - NUM_REQ'(1)));

    // Pointer, read-return marker and contention counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr           <= 3'd0;
            rdata_valid_q <= '0;
            contention_q  <= 16'd0;
        end else begin
            ptr           <= ptr_next;
            rdata_valid_q <= grant_oh & bus.req_read;
            if (multi_req && (contention_q != 16'hFFFF))
                contention_q <= contention_q + 16'd1;
        end
    end

    assign bus.grant_oh         = grant_oh;
    assign bus.grant_id         = sel_hit ? sel_id : 3'd0;
    assign bus.grant_valid      = sel_hit;
    assign bus.rdata_valid_oh   = rdata_valid_q;
    assign bus.contention_count = contention_q;

endmodule

// File: tb/tb_gmem_scheduler.sv
// Bench for gmem_scheduler: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model.
module tb_gmem_scheduler;

    localparam int N        = 8;
    localparam int MAX_LOCK = 4;

    logic clk;
    logic reset;

    gmem_scheduler_if #(.NUM_REQ(N)) bus ();

    gmem_scheduler #(.NUM_REQ(N), .MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model state
    int         m_ptr;
    logic [7:0] m_rv;
    int         m_cnt;
    bit         m_lk_act;
    int         m_lk_own;
    int         m_lk_run;
    int         obs_id;
    logic [7:0] obs_oh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_rv     = '0;
        m_cnt    = 0;
        m_lk_act = 0;
        m_lk_own = 0;
        m_lk_run = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, advance model.
    task automatic cycle(input logic [7:0] req, input logic [7:0] rd, input logic [7:0] lk);
        logic [7:0] e_oh;
        int         e_id;
        bit         e_v;
        int         run;
        bit         keep;
        bus.request  = req;
        bus.req_read = rd;
        bus.lock     = lk;
        #4;
        e_v  = 0;
        e_id = 0;
        e_oh = '0;
        run  = 1;
        keep = 0;
`ifdef GMEM_ARB_LOCK_EN
        if (m_lk_act && req[m_lk_own]) begin
            e_v  = 1;
            e_id = m_lk_own;
            run  = m_lk_run + 1;
        end
`endif
        if (!e_v) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    e_v  = 1;
                    e_id = (m_ptr + k) % N;
                    break;
                end
            end
        end
        if (e_v) e_oh[e_id] = 1'b1;
`ifdef GMEM_ARB_LOCK_EN
        keep = e_v && lk[e_id] && (run < MAX_LOCK);
`endif
        obs_id = int'(bus.grant_id);
        obs_oh = bus.grant_oh;
        check("grant_oh",         32'(bus.grant_oh),         32'(e_oh));
        check("grant_id",         32'(bus.grant_id),         32'(e_id));
        check("grant_valid",      32'(bus.grant_valid),      32'(e_v));
        check("rdata_valid_oh",   32'(bus.rdata_valid_oh),   32'(m_rv));
        check("contention_count", 32'(bus.contention_count), 32'(m_cnt));
        if (!reset) begin
            model_reset();
        end else begin
            m_rv = e_oh & rd;
            if ($countones(req) >= 2 && m_cnt < 65535) m_cnt++;
            if (keep) begin
                m_lk_act = 1;
                m_lk_own = e_id;
                m_lk_run = run;
            end else begin
                m_lk_act = 0;
                m_lk_run = 0;
                if (e_v) m_ptr = (e_id + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(8'h00, 8'h00, 8'h00);
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset        = 1'b0;
        bus.request  = '0;
        bus.req_read = '0;
        bus.lock     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", 32'(bus.rdata_valid_oh),   32'h0);
        check("reset_count", 32'(bus.contention_count), 32'h0);
        reset = 1'b1;

        // All cores requesting: strict rotation 0..7, 8 contended cycles
        for (int k = 0; k < 8; k++) begin
            cycle(8'hFF, 8'h00, 8'h00);
            check("rotate_id", 32'(obs_id), 32'(k));
        end
        check("rotate_count", 32'(bus.contention_count), 32'd8);

        // Cores 0 and 7 reading: grants 0 then 7, markers follow a cycle later
        cycle(8'h81, 8'hFF, 8'h00);
        check("r81_first_id", 32'(obs_id), 32'd0);
        check("r81_rv0", 32'(bus.rdata_valid_oh), 32'h01);
        cycle(8'h81, 8'hFF, 8'h00);
        check("r81_second_id", 32'(obs_id), 32'd7);
        check("r81_rv1", 32'(bus.rdata_valid_oh), 32'h80);
        cycle(8'h00, 8'h00, 8'h00);
        check("r81_rv_idle", 32'(bus.rdata_valid_oh), 32'h00);

        // Lone writer on core 5
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(8'h20, 8'h00, 8'h00);
            check("w5_grant", 32'(obs_oh), 32'h20);
            check("w5_rv", 32'(bus.rdata_valid_oh), 32'h00);
            check("w5_count", 32'(bus.contention_count), 32'h0);
        end

        // Reset right after a granted read discards the pending marker
        cycle(8'h04, 8'h04, 8'h00);
        reset = 1'b0;
        cycle(8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        check("rst_rd_rv", 32'(bus.rdata_valid_oh), 32'h00);
        cycle(8'hFF, 8'h00, 8'h00);
        check("rst_rd_ptr", 32'(obs_id), 32'd0);
        check("rst_rd_rv2", 32'(bus.rdata_valid_oh), 32'h00);

`ifdef GMEM_ARB_LOCK_EN
        // Core 2 holds a lock against core 3: four grants then core 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(8'h0C, 8'h00, 8'h04);
            check("lock_seq", 32'(obs_id), (k < MAX_LOCK) ? 32'd2 : 32'd3);
        end
`endif

        // Randomized traffic with occasional resets
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic [7:0] rq;
            rq = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rq = rq & 8'($urandom_range(0, 255));
            reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            cycle(rq, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        reset = 1'b1;

        // Long contention: counter must saturate
        do_reset();
        for (int k = 0; k < 70000; k++) cycle(8'hFF, 8'h00, 8'h00);
        check("sat_count", 32'(bus.contention_count), 32'h0000FFFF);
        cycle(8'h03, 8'h00, 8'h00);
        check("sat_hold", 32'(bus.contention_count), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
